// File: rtl/car_drive_fsm.sv
// Manual-drive control FSM: driver switches -> 2-bit car state plus gated turn/reverse requests.
// Optional stall behaviour enabled by defining CAR_STALL_EN; all outputs registered, 1-cycle latency.
module car_drive_fsm #(
  parameter int HOLD_CYCLES = 100_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       power_on,
  input  logic       power_off,
  input  logic       throttle,
  input  logic       clutch,
  input  logic       brake,
  input  logic       reverse_sw,
  input  logic       turn_left_sw,
  input  logic       turn_right_sw,
  output logic [1:0] state,
  output logic       turn_left,
  output logic       turn_right,
  output logic       reverse
);

  localparam int CW = $clog2(HOLD_CYCLES);

  localparam logic [1:0] ST_OFF       = 2'b00;
  localparam logic [1:0] ST_NOT_START = 2'b01;
  localparam logic [1:0] ST_STARTING  = 2'b10;
  localparam logic [1:0] ST_MOVING    = 2'b11;

  localparam logic [CW-1:0] CNT_LAST = CW'(HOLD_CYCLES - 1);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          turn_left_q, turn_left_d;
  logic          turn_right_q, turn_right_d;
  logic          reverse_q, reverse_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    if (power_off) begin
      state_d = ST_OFF;
    end else begin
      case (state_q)
        ST_OFF: begin
          // Transition fires on the last count, so the counter never wraps.
          if (power_on) begin
            if (cnt_q == CNT_LAST) state_d = ST_NOT_START;
            else                   cnt_d   = cnt_q + 1'b1;
          end
        end
        ST_NOT_START: begin
          if (throttle && clutch && !brake) state_d = ST_STARTING;
`ifdef CAR_STALL_EN
          else if (throttle && !clutch)     state_d = ST_OFF;
`endif
        end
        ST_STARTING: begin
          if (brake)                        state_d = ST_NOT_START;
          else if (throttle && !clutch)     state_d = ST_MOVING;
        end
        ST_MOVING: begin
          if (brake)                        state_d = ST_NOT_START;
`ifdef CAR_STALL_EN
          else if ((reverse_sw != reverse_q) && !clutch) state_d = ST_OFF;
`endif
          else if (clutch || !throttle)     state_d = ST_STARTING;
        end
        default:                            state_d = ST_OFF;
      endcase
    end
  end

  // Outputs gate on the next state so they are already valid on the first NOT_START cycle.
  always_comb begin
    turn_left_d  = 1'b0;
    turn_right_d = 1'b0;
    reverse_d    = 1'b0;
    if (state_d != ST_OFF) begin
      turn_left_d  = turn_left_sw;
      turn_right_d = turn_right_sw;
      // Gear cannot change while moving with the clutch released.
      reverse_d    = (state_q == ST_MOVING && !clutch) ? reverse_q : reverse_sw;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_OFF;
      cnt_q        <= '0;
      turn_left_q  <= 1'b0;
      turn_right_q <= 1'b0;
      reverse_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      turn_left_q  <= turn_left_d;
      turn_right_q <= turn_right_d;
      reverse_q    <= reverse_d;
    end
  end

  assign state      = state_q;
  assign turn_left  = turn_left_q;
  assign turn_right = turn_right_q;
  assign reverse    = reverse_q;

endmodule

// File: tb/tb_car_drive_fsm.sv
// Directed bench for car_drive_fsm with HOLD_CYCLES=4; expectations follow CAR_STALL_EN when defined.
module tb_car_drive_fsm;

  logic       clk = 1'b0;
  logic       rst, power_on, power_off, throttle, clutch, brake;
  logic       reverse_sw, turn_left_sw, turn_right_sw;
  logic [1:0] state;
  logic       turn_left, turn_right, reverse;

  car_drive_fsm #(.HOLD_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .power_on(power_on), .power_off(power_off),
    .throttle(throttle), .clutch(clutch), .brake(brake), .reverse_sw(reverse_sw),
    .turn_left_sw(turn_left_sw), .turn_right_sw(turn_right_sw),
    .state(state), .turn_left(turn_left), .turn_right(turn_right), .reverse(reverse)
  );

  always #5 clk = ~clk;

  // Input bit positions: {rst, pon, poff, thr, clu, brk, rsw, tl, tr}
  localparam logic [8:0] R    = 9'h100;
  localparam logic [8:0] PON  = 9'h080;
  localparam logic [8:0] POFF = 9'h040;
  localparam logic [8:0] THR  = 9'h020;
  localparam logic [8:0] CLU  = 9'h010;
  localparam logic [8:0] BRK  = 9'h008;
  localparam logic [8:0] RSW  = 9'h004;
  localparam logic [8:0] TL   = 9'h002;
  localparam logic [8:0] TR   = 9'h001;
  localparam logic [8:0] NONE = 9'h000;

  typedef struct {
    string      name;
    logic [8:0] in;
    logic [4:0] exp;  // {state, turn_left, turn_right, reverse}
  } vec_t;

  vec_t vecs[$];
  int   tests = 0;
  int   fails = 0;

  function automatic logic [4:0] e(logic [1:0] st, logic tl, logic tr, logic rv);
    return {st, tl, tr, rv};
  endfunction

  task automatic add(input string name, input logic [8:0] in, input logic [4:0] exp);
    vec_t v;
    v.name = name;
    v.in   = in;
    v.exp  = exp;
    vecs.push_back(v);
  endtask

  // Drive one cycle of inputs away from the edge, then sample just after the edge.
  task automatic step(input string name, input logic [8:0] in, input logic [4:0] exp);
    logic [4:0] act;
    @(negedge clk);
    {rst, power_on, power_off, throttle, clutch, brake, reverse_sw, turn_left_sw, turn_right_sw} = in;
    @(posedge clk);
    #1;
    act = {state, turn_left, turn_right, reverse};
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got st=%b tl=%b tr=%b rev=%b, want st=%b tl=%b tr=%b rev=%b",
               name, act[4:3], act[2], act[1], act[0], exp[4:3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic power_up(input string name, input logic [8:0] extra);
    for (int i = 0; i < 3; i++) step({name, "_hold"}, PON | extra, e(2'b00, 0, 0, 0));
    step({name, "_on"}, PON | extra, e(2'b01, extra[1], extra[0], extra[2]));
  endtask

  initial begin
    {rst, power_on, power_off, throttle, clutch, brake, reverse_sw, turn_left_sw, turn_right_sw} = R;

    add("reset",          R,              e(2'b00, 0, 0, 0));
    add("pon_short1",     PON,            e(2'b00, 0, 0, 0));
    add("pon_short2",     PON,            e(2'b00, 0, 0, 0));
    add("pon_short3",     PON,            e(2'b00, 0, 0, 0));
    add("pon_gap",        NONE,           e(2'b00, 0, 0, 0));
    add("pon_cnt1_turns", PON | TL | TR,  e(2'b00, 0, 0, 0));
    add("pon_cnt2_turns", PON | TL | TR,  e(2'b00, 0, 0, 0));
    add("pon_cnt3_turns", PON | TL | TR,  e(2'b00, 0, 0, 0));
    add("pon_4th_edge",   PON | TL,       e(2'b01, 1, 0, 0));
    add("turn_01",        TR,             e(2'b01, 0, 1, 0));
    add("turn_11",        TL | TR,        e(2'b01, 1, 1, 0));
    add("turn_10",        TL,             e(2'b01, 1, 0, 0));
    add("turn_00",        NONE,           e(2'b01, 0, 0, 0));
    add("drv_starting",   THR | CLU,      e(2'b10, 0, 0, 0));
    add("drv_moving",     THR,            e(2'b11, 0, 0, 0));
    add("drv_brake",      THR | BRK,      e(2'b01, 0, 0, 0));
    add("drv_starting2",  THR | CLU | RSW | TL, e(2'b10, 1, 0, 1));
    add("drv_power_off",  POFF | TL | TR | RSW | THR, e(2'b00, 0, 0, 0));
    add("off_turn_01",    TR,             e(2'b00, 0, 0, 0));
    add("off_turn_11",    TL | TR,        e(2'b00, 0, 0, 0));
    add("off_turn_10",    TL,             e(2'b00, 0, 0, 0));
    add("both_cnt1",      PON,            e(2'b00, 0, 0, 0));
    add("both_cnt2",      PON,            e(2'b00, 0, 0, 0));
    add("both_on_off",    PON | POFF,     e(2'b00, 0, 0, 0));
    add("after_clr1",     PON,            e(2'b00, 0, 0, 0));
    add("after_clr2",     PON,            e(2'b00, 0, 0, 0));
    add("after_clr3",     PON,            e(2'b00, 0, 0, 0));
    add("after_clr4",     PON,            e(2'b01, 0, 0, 0));

    foreach (vecs[i]) step(vecs[i].name, vecs[i].in, vecs[i].exp);

    // Stall corner cases: NOT_START throttle without clutch, MOVING gear change without clutch.
`ifdef CAR_STALL_EN
    step("stall_ns",        THR,             e(2'b00, 0, 0, 0));
    power_up("repower1", NONE);
    step("st_starting",     THR | CLU,       e(2'b10, 0, 0, 0));
    step("st_moving",       THR,             e(2'b11, 0, 0, 0));
    step("stall_mv",        THR | RSW,       e(2'b00, 0, 0, 0));
    power_up("repower2", NONE);
`else
    step("nostall_ns",      THR,             e(2'b01, 0, 0, 0));
    step("ns_starting",     THR | CLU,       e(2'b10, 0, 0, 0));
    step("ns_moving",       THR,             e(2'b11, 0, 0, 0));
    step("nostall_mv1",     THR | RSW,       e(2'b11, 0, 0, 0));
    step("nostall_mv2",     THR | RSW,       e(2'b11, 0, 0, 0));
    step("gear_on_clutch",  THR | CLU | RSW, e(2'b10, 0, 0, 1));
    step("back_to_ns",      BRK | RSW,       e(2'b01, 0, 0, 1));
`endif

    // Priority: brake beats clutch in MOVING.
    step("pr_starting",     THR | CLU | RSW,       e(2'b10, 0, 0, 1));
    step("pr_moving",       THR | RSW,             e(2'b11, 0, 0, 1));
    step("pr_brake_clutch", THR | CLU | BRK | RSW, e(2'b01, 0, 0, 1));

    // Reset mid-drive overrides every input, then power-up needs a full count.
    step("rd_starting",     THR | CLU | RSW,       e(2'b10, 0, 0, 1));
    step("rd_moving",       THR | RSW | TR,        e(2'b11, 0, 1, 1));
    step("rd_reset",        R | PON | THR | RSW | TL | TR, e(2'b00, 0, 0, 0));
    power_up("rd_repower", TL);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, got %0d tests, want completion", tests);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/car_drive_fsm.md
# car_drive_fsm

Manual-drive control state machine for the car simulation. Turns raw driver inputs (power buttons, throttle, clutch, brake, reverse and turn switches) into the 2-bit car state plus gated turn and reverse requests. Sits directly upstream of `car_LED`, feeding its `state`, `turn_left` and `turn_right` inputs, and upstream of the motion/output logic.

## Interface
- `HOLD_CYCLES`, 100_000_000: consecutive cycles `power_on` must be high to power up (1 s at 100 MHz); minimum 2.
- `clk` input 1: system clock, all logic on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `power_on` input 1: power-on button, level.
- `power_off` input 1: power-off button, level.
- `throttle` input 1: throttle switch.
- `clutch` input 1: clutch switch.
- `brake` input 1: brake switch.
- `reverse_sw` input 1: reverse gear switch.
- `turn_left_sw` input 1: left turn switch.
- `turn_right_sw` input 1: right turn switch.
- `state` output 2: 00 OFF, 01 NOT_START, 10 STARTING, 11 MOVING; registered.
- `turn_left` output 1: registered `turn_left_sw`, forced 0 in OFF.
- `turn_right` output 1: registered `turn_right_sw`, forced 0 in OFF.
- `reverse` output 1: registered gear, forced 0 in OFF.

## Operation
- Reset: `state`=00, `turn_left`=`turn_right`=`reverse`=0, hold counter=0.
- Counter width `$clog2(HOLD_CYCLES)`; increments each cycle `state`=OFF and `power_on`=1 and `power_off`=0; clears otherwise; never wraps (transition fires first).
- Global: `power_off`=1 in any state → OFF next edge; highest priority, clears counter.
- OFF → NOT_START: counter = HOLD_CYCLES-1 and `power_on`=1.
- NOT_START (priority top-down): `throttle`&`clutch`&!`brake` → STARTING; `throttle`&!`clutch` → OFF (stall, see Configuration); else hold.
- STARTING: `brake` → NOT_START; `throttle`&!`clutch` → MOVING; else hold.
- MOVING: `brake` → NOT_START; `reverse_sw`≠`reverse` & !`clutch` → OFF (stall); `clutch` | !`throttle` → STARTING; else hold.
- Gear: `reverse` loads `reverse_sw` every cycle when state ≠ OFF, except in MOVING without `clutch`, where it holds (mismatch is the stall condition).
- Turn outputs independent of other inputs; both switches high → both outputs high.
- Leaving OFF: outputs reflect switches from the first cycle in NOT_START onward.

## Timing
- All outputs registered; state and output change on the edge that samples the causing inputs (1-cycle latency, no combinational input→output path).
- Power-up: `power_on` high on HOLD_CYCLES consecutive edges → `state`=01 after the HOLD_CYCLES-th edge. A single low cycle restarts the count.
- `power_on` and `power_off` simultaneous: OFF, counter cleared.
- `rst` mid-operation: all outputs to reset values on that edge, overriding every input.
- No input synchronisation or debouncing inside; inputs arrive synchronous to `clk`.

## Configuration
- `CAR_STALL_EN` defined: both stall transitions active (NOT_START throttle without clutch → OFF; MOVING gear change without clutch → OFF).
- Undefined: stall conditions ignored. NOT_START with `throttle`&!`clutch` holds. In MOVING, `reverse` holds its value until `clutch`=1 or the state leaves MOVING, and the state follows the remaining rules.

## Test plan
Run with HOLD_CYCLES=4.
- Power-up: `power_on`=1 for 3 cycles then 0 → `state` stays 00. Then 4 cycles high → `state`=01 after 4th edge.
- Drive sequence: `throttle`=`clutch`=1 → 10; `clutch`=0 → 11; `brake`=1 → 01; `power_off`=1 → 00 with all outputs 0.
- Turns: in 01, `turn_left_sw`/`turn_right_sw` = 01, 11, 10 → outputs follow one cycle later. In 00 the same stimulus gives outputs 00.
- Stall, with `CAR_STALL_EN`: in 01, `throttle`=1 and `clutch`=0 → 00. In 11, toggle `reverse_sw` with `clutch`=0 → 00. Without the macro, the states stay 01 and 11, and `reverse` is unchanged until `clutch`=1.
- Priority: in 11, `brake`=1 and `clutch`=1 → 01. `power_off`=1 and `power_on`=1 together in 00 → stays 00, counter 0.
- Reset mid-drive: in 11 with `reverse`=1, assert `rst` one cycle → `state`=00, `reverse`=0. The next power-up needs a full 4 cycles.
